// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types: instruction word type, NOP constant and fetch FSM states.
package common;

  typedef logic [31:0] instruction_type;

  localparam instruction_type NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_BUF
  } fetch_state_e;

  function automatic logic is_compressed(input logic [15:0] parcel);
    return parcel[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_stage_realigner.sv
// Combinational parcel assembly: turns the held halfword plus an optional memory word
// into at most one instruction and the halfword left over for the next cycle.
module fetch_realigner
  import common::*;
(
  input  logic [15:0]     hbuf,
  input  logic            hbuf_valid,
  input  logic [31:0]     word,
  input  logic            word_valid,
  input  logic            pc_hi,
  output logic            emit,
  output instruction_type instr,
  output logic            compflg,
  output logic            word_used,
  output logic [15:0]     hbuf_new,
  output logic            hbuf_new_valid
);

  always_comb begin
    emit           = 1'b0;
    instr          = word;
    compflg        = 1'b0;
    word_used      = 1'b0;
    hbuf_new       = hbuf;
    hbuf_new_valid = hbuf_valid;
    // hbuf always holds the halfword at next_pc, so a valid hbuf implies pc_hi=1
    if (hbuf_valid) begin
      if (is_compressed(hbuf)) begin
        emit           = 1'b1;
        instr          = {16'h0000, hbuf};
        compflg        = 1'b1;
        hbuf_new_valid = 1'b0;
      end else if (word_valid) begin
        emit           = 1'b1;
        instr          = {word[15:0], hbuf};
        word_used      = 1'b1;
        hbuf_new       = word[31:16];
        hbuf_new_valid = 1'b1;
      end
    end else if (word_valid) begin
      word_used = 1'b1;
      hbuf_new  = word[31:16];
      if (!pc_hi) begin
        emit = 1'b1;
        if (is_compressed(word[15:0])) begin
          instr          = {16'h0000, word[15:0]};
          compflg        = 1'b1;
          hbuf_new_valid = 1'b1;
        end else begin
          instr          = word;
          hbuf_new_valid = 1'b0;
        end
      end else if (is_compressed(word[31:16])) begin
        emit           = 1'b1;
        instr          = {16'h0000, word[31:16]};
        compflg        = 1'b1;
        hbuf_new_valid = 1'b0;
      end else begin
        hbuf_new_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding word reads, RVC parcel realignment,
// registered outputs with stall hold and flush redirect.
module fetch_stage
  import common::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic [31:0]     flush_target,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            valid,
  output instruction_type instruction,
  output logic [31:0]     pc,
  output logic            compflg
);

  fetch_state_e    state_q, state_d;
  logic [31:0]     next_pc_q, next_pc_d;
  logic [15:0]     hbuf_q, hbuf_d;
  logic            hbuf_valid_q, hbuf_valid_d;
  logic [31:0]     rbuf_q, rbuf_d;
  logic            rbuf_valid_q, rbuf_valid_d;
  logic            drop_q, drop_d;
  logic            valid_q, valid_d;
  instruction_type instr_q, instr_d;
  logic [31:0]     pc_q, pc_d;
  logic            compflg_q, compflg_d;

  logic            mem_word_valid, word_valid;
  logic [31:0]     word, fetch_addr;
  logic            ra_emit, ra_compflg, ra_word_used, ra_hbuf_valid;
  instruction_type ra_instr;
  logic [15:0]     ra_hbuf;

  assign mem_word_valid = imem_rvalid && !drop_q && !flush;
  assign word_valid     = rbuf_valid_q || mem_word_valid;
  assign word           = rbuf_valid_q ? rbuf_q : imem_rdata;
  assign fetch_addr     = hbuf_valid_q ? next_pc_q + 32'd2 : next_pc_q;
  assign imem_addr      = fetch_addr & ~32'h3;
  assign imem_req       = rst_n && (state_q == S_REQ) && !rbuf_valid_q && !drop_q && !flush;

  fetch_realigner u_realigner (
    .hbuf          (hbuf_q),
    .hbuf_valid    (hbuf_valid_q),
    .word          (word),
    .word_valid    (word_valid),
    .pc_hi         (next_pc_q[1]),
    .emit          (ra_emit),
    .instr         (ra_instr),
    .compflg       (ra_compflg),
    .word_used     (ra_word_used),
    .hbuf_new      (ra_hbuf),
    .hbuf_new_valid(ra_hbuf_valid)
  );

  always_comb begin
    next_pc_d    = next_pc_q;
    hbuf_d       = hbuf_q;
    hbuf_valid_d = hbuf_valid_q;
    rbuf_d       = rbuf_q;
    rbuf_valid_d = rbuf_valid_q;
    drop_d       = drop_q && !imem_rvalid;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    compflg_d    = compflg_q;

    if (!stall) begin
      if (ra_word_used) rbuf_valid_d = 1'b0;
      hbuf_d       = ra_hbuf;
      hbuf_valid_d = ra_hbuf_valid;
      valid_d      = ra_emit;
      if (ra_emit) begin
        instr_d   = ra_instr;
        pc_d      = next_pc_q;
        compflg_d = ra_compflg;
        next_pc_d = next_pc_q + (ra_compflg ? 32'd2 : 32'd4);
      end
    end
    // A response the realigner could not take this cycle is parked until stall drops
    if (mem_word_valid && (stall || !ra_word_used)) begin
      rbuf_d       = imem_rdata;
      rbuf_valid_d = 1'b1;
    end

    if (hbuf_valid_d && is_compressed(hbuf_d))          state_d = S_BUF;
    else if (imem_req)                                   state_d = S_WAIT;
    else if ((state_q == S_WAIT) && !imem_rvalid)        state_d = S_WAIT;
    else                                                 state_d = S_REQ;

    if (flush) begin
      valid_d      = 1'b0;
      next_pc_d    = flush_target & ~32'h1;
      hbuf_valid_d = 1'b0;
      rbuf_valid_d = 1'b0;
      state_d      = S_REQ;
      // Only a response still in flight needs dropping; one arriving now is ignored above
      drop_d       = ((state_q == S_WAIT) || drop_q) && !imem_rvalid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      next_pc_q    <= RESET_PC;
      hbuf_q       <= '0;
      hbuf_valid_q <= 1'b0;
      rbuf_q       <= '0;
      rbuf_valid_q <= 1'b0;
      drop_q       <= 1'b0;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc_q         <= '0;
      compflg_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_pc_q    <= next_pc_d;
      hbuf_q       <= hbuf_d;
      hbuf_valid_q <= hbuf_valid_d;
      rbuf_q       <= rbuf_d;
      rbuf_valid_q <= rbuf_valid_d;
      drop_q       <= drop_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      compflg_q    <= compflg_d;
    end
  end

  assign valid       = valid_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign compflg     = compflg_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: 1-cycle memory model, program-order reference
// decoder over a halfword view of memory, directed scenarios then randomized stall/flush.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, imem_req, imem_rvalid, valid, compflg;
  logic [31:0] flush_target, imem_addr, imem_rdata, instruction, pc;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .flush_target(flush_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .valid       (valid),
    .instruction (instruction),
    .pc          (pc),
    .compflg     (compflg)
  );

  logic [31:0] mem [0:1023];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] ref_pc;
  bit          pend;
  logic [31:0] pend_addr;
  bit          prev_stall, prev_flush;
  logic        prev_valid, prev_comp;
  logic [31:0] prev_pc, prev_instr, last_req_addr, first_req_addr;
  int          cyc, acc_cnt, reads, first_req_cyc, first_valid_cyc;
  logic [31:0] acc_pc [8];
  int          acc_cyc [8];
  int          acc_reads [8];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] half(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[11:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Program-order decode: {compflg, instruction} of the instruction starting at a
  function automatic logic [32:0] ref_fetch(input logic [31:0] a);
    logic [15:0] h0;
    h0 = half(a);
    if (h0[1:0] != 2'b11) return {1'b1, 16'h0000, h0};
    return {1'b0, half(a + 32'd2), h0};
  endfunction

  task automatic fill_nops();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; flush_target = '0;
    imem_rvalid = 1'b0; imem_rdata = '0; pend = 1'b0;
    #1;
    check("rst_valid",   128'(valid),       128'(1'b0));
    check("rst_instr",   128'(instruction), 128'(32'h0000_0013));
    check("rst_pc",      128'(pc),          128'(32'h0));
    check("rst_compflg", 128'(compflg),     128'(1'b0));
    check("rst_req",     128'(imem_req),    128'(1'b0));
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ref_pc = 32'h0; prev_flush = 1'b0; prev_stall = 1'b0;
    cyc = 0; acc_cnt = 0; reads = 0; first_req_cyc = -1; first_valid_cyc = -1;
  endtask

  task automatic step(input bit st, input bit fl, input logic [31:0] tgt);
    logic [32:0] e;
    @(negedge clk);
    imem_rvalid  = pend;
    imem_rdata   = pend ? mem[pend_addr[11:2]] : $urandom;
    stall        = st;
    flush        = fl;
    flush_target = tgt;
    #1;
    cyc++;
    if (prev_flush)
      check("valid_after_flush", 128'(valid), 128'(1'b0));
    else if (prev_stall)
      check("held_outputs", 128'({valid, compflg, pc, instruction}),
            128'({prev_valid, prev_comp, prev_pc, prev_instr}));
    if (valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (valid && !st && !fl) begin
      e = ref_fetch(ref_pc);
      check("pc",      128'(pc),          128'(ref_pc));
      check("instr",   128'(instruction), 128'(e[31:0]));
      check("compflg", 128'(compflg),     128'(e[32]));
      if (acc_cnt < 8) begin
        acc_pc[acc_cnt] = pc; acc_cyc[acc_cnt] = cyc; acc_reads[acc_cnt] = reads;
      end
      acc_cnt++;
      ref_pc = ref_pc + (e[32] ? 32'd2 : 32'd4);
    end
    if (fl) ref_pc = {tgt[31:1], 1'b0};
    if (imem_req) begin
      check("addr_align",      128'(imem_addr[1:0]), 128'(2'b00));
      check("one_outstanding", 128'(pend),           128'(1'b0));
      if (first_req_cyc < 0) begin first_req_cyc = cyc; first_req_addr = imem_addr; end
      reads++;
      last_req_addr = imem_addr;
    end
    pend = imem_req; pend_addr = imem_addr;
    prev_stall = st; prev_flush = fl;
    prev_valid = valid; prev_comp = compflg; prev_pc = pc; prev_instr = instruction;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; flush_target = '0;
    imem_rvalid = 1'b0; imem_rdata = '0; pend = 1'b0;

    // First fetch after reset: 32-bit instruction, two-cycle latency
    fill_nops(); mem[0] = 32'h0050_0093;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
    check("first_req_addr", 128'(first_req_addr), 128'(32'h0));
    check("req_to_valid",   128'(first_valid_cyc - first_req_cyc), 128'(2));
    check("first_pc",       128'(acc_pc[0]), 128'(32'h0));

    // Two compressed parcels from one word, back to back, one read
    fill_nops(); mem[0] = 32'h4505_4501;
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
    check("c_pair_second_pc", 128'(acc_pc[1]), 128'(32'h2));
    check("c_pair_b2b",       128'(acc_cyc[1] - acc_cyc[0]), 128'(1));
    check("c_pair_reads",     128'(acc_reads[1]), 128'(1));

    // 32-bit instruction spanning a word boundary
    fill_nops(); mem[0] = 32'h0093_4501; mem[1] = 32'h1234_0050;
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);
    check("span_pc",    128'(acc_pc[1]), 128'(32'h2));
    check("span_count", 128'(acc_cnt >= 2), 128'(1'b1));

    // Flush while a read is outstanding
    fill_nops(); mem[0] = 32'h4505_4501; mem[32'h40] = 32'h0001_1111;
    do_reset();
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h0000_0103);
    step(1'b0, 1'b0, '0);
    check("flush_fetch_addr", 128'(last_req_addr), 128'(32'h100));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
    check("flush_first_pc", 128'(acc_pc[0]), 128'(32'h102));

    // Stall while the response arrives, then flush under stall
    fill_nops(); mem[0] = 32'h0050_0093;
    do_reset();
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
    check("stall_reads", 128'(reads), 128'(1));
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    check("stall_release_valid", 128'(first_valid_cyc), 128'(6));
    step(1'b1, 1'b1, 32'h0000_0200);
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);

    // Randomized program, stalls, flushes (including near the top of the address space)
    for (int i = 0; i < 1024; i++) begin
      logic [15:0] lo, hi;
      lo = 16'($urandom); hi = 16'($urandom);
      if ($urandom_range(1, 0) == 1) lo[1:0] = 2'b11;
      if ($urandom_range(1, 0) == 1) hi[1:0] = 2'b11;
      mem[i] = {hi, lo};
    end
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      if ($urandom_range(7, 0) == 0) tgt = 32'hFFFF_FFF8 + 32'($urandom_range(7, 0));
      else                           tgt = $urandom & 32'h0000_0FFF;
      if (i == 1500) do_reset();
      step($urandom_range(3, 0) == 0, $urandom_range(39, 0) == 0, tgt);
    end
    check("progress", 128'(acc_cnt > 100), 128'(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
